text_lcd_responder: RTL and testbench

HD44780-compatible bus responder: the receiving end of the character-LCD write interface produced by `text_lcd_driver`. It samples `lcd_rs/lcd_rw/lcd_en/lcd_data`, decodes instructions and data writes, and maintains a 2×16 DDRAM image. The image is returned as two 128-bit line buffers in the same packing the driver consumes. It also checks driver timing against HD44780 busy times. Used as the display model in the top-level bench and as an on-chip debug mirror.

---
 rtl/lcd_pkg.sv | 60 ++++++
 rtl/lcd_bus_sampler.sv | 83 ++++++++
 rtl/text_lcd_responder.sv | 180 ++++++++++++++++++
 tb/tb_text_lcd_responder.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-compatible bus responder.
// Holds the instruction opcode masks, the DDRAM line bases and wrap limits,
// the blank character, the default busy times and the address-counter step
// helper used by the responder top level.
package lcd_pkg;

    // Instruction opcode masks; an instruction is classified by its highest set bit.
    localparam logic [7:0] OP_CLEAR   = 8'h01;
    localparam logic [7:0] OP_HOME    = 8'h02;
    localparam logic [7:0] OP_ENTRY   = 8'h04;
    localparam logic [7:0] OP_DISPCTL = 8'h08;
    localparam logic [7:0] OP_SHIFT   = 8'h10;
    localparam logic [7:0] OP_FUNC    = 8'h20;
    localparam logic [7:0] OP_CGRAM   = 8'h40;
    localparam logic [7:0] OP_DDRAM   = 8'h80;

    // DDRAM line bases and the last address of each 40-character line.
    localparam logic [6:0] LINE1_BASE = 7'h00;
    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE1_LAST = 7'h27;
    localparam logic [6:0] LINE2_LAST = 7'h67;

    localparam logic [7:0] LCD_SPACE = 8'h20;

    // Default busy times in clock cycles at 50 MHz.
    localparam int BUSY_SHORT_DEF = 2000;
    localparam int BUSY_LONG_DEF  = 82000;

    // Which busy time an accepted write reloads.
    typedef enum logic [1:0] {
        BUSY_NONE  = 2'd0,
        BUSY_SHORT = 2'd1,
        BUSY_LONG  = 2'd2
    } busy_load_e;

    // One address-counter step with the two-line wrap. Addresses outside the
    // line windows simply step by one so an invalid AC drifts predictably.
    function automatic logic [6:0] ac_step(input logic [6:0] ac, input logic inc);
        logic [6:0] nxt;
        if (inc) begin
            if (ac == LINE1_LAST) begin
                nxt = LINE2_BASE;
            end else if (ac == LINE2_LAST) begin
                nxt = LINE1_BASE;
            end else begin
                nxt = ac + 7'd1;
            end
        end else begin
            if (ac == LINE2_BASE) begin
                nxt = LINE1_LAST;
            end else if (ac == LINE1_BASE) begin
                nxt = LINE2_LAST;
            end else begin
                nxt = ac - 7'd1;
            end
        end
        return nxt;
    endfunction

endpackage

// File: rtl/lcd_bus_sampler.sv
// Brings the asynchronous character-LCD bus into the clock domain and turns
// each falling edge of the enable strobe into a one-cycle transfer.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   lcd_rs/rw/en/data     raw bus pins
//   xfer_valid            one-cycle pulse, one per detected enable fall
//   xfer_rs/rw/data       bus values captured at that fall (held until next)
module lcd_bus_sampler
    import lcd_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic       lcd_en,
    input  logic [7:0] lcd_data,
    output logic       xfer_valid,
    output logic       xfer_rs,
    output logic       xfer_rw,
    output logic [7:0] xfer_data
);

    logic       s1_rs_r, s1_rw_r, s1_en_r;
    logic [7:0] s1_data_r;
    logic       s2_rs_r, s2_rw_r, s2_en_r;
    logic [7:0] s2_data_r;
    logic       valid_r, rs_r, rw_r;
    logic [7:0] data_r;
    logic       fall_s;

    // The newer stage is low while the older stage is still high: enable just fell.
    assign fall_s = s2_en_r & ~s1_en_r;

    // Two-stage synchronizer for all bus pins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_rs_r   <= 1'b0;
            s1_rw_r   <= 1'b0;
            s1_en_r   <= 1'b0;
            s1_data_r <= 8'h00;
            s2_rs_r   <= 1'b0;
            s2_rw_r   <= 1'b0;
            s2_en_r   <= 1'b0;
            s2_data_r <= 8'h00;
        end else begin
            s1_rs_r   <= lcd_rs;
            s1_rw_r   <= lcd_rw;
            s1_en_r   <= lcd_en;
            s1_data_r <= lcd_data;
            s2_rs_r   <= s1_rs_r;
            s2_rw_r   <= s1_rw_r;
            s2_en_r   <= s1_en_r;
            s2_data_r <= s1_data_r;
        end
    end

    // Capture register: the s2 copies are the ones aligned with the enable still high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            rs_r    <= 1'b0;
            rw_r    <= 1'b0;
            data_r  <= 8'h00;
        end else begin
            valid_r <= fall_s;
            if (fall_s) begin
                rs_r   <= s2_rs_r;
                rw_r   <= s2_rw_r;
                data_r <= s2_data_r;
            end else begin
                rs_r   <= rs_r;
                rw_r   <= rw_r;
                data_r <= data_r;
            end
        end
    end

    assign xfer_valid = valid_r;
    assign xfer_rs    = rs_r;
    assign xfer_rw    = rw_r;
    assign xfer_data  = data_r;

endmodule

// File: rtl/text_lcd_responder.sv
// HD44780-compatible write responder. Decodes instructions and data writes
// from the character-LCD bus, keeps a 2x16 DDRAM image, the address counter,
// entry direction and display-on bit, and flags writes made while busy.
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   lcd_rs/rw/en/data     bus pins from the driver
//   line1_buffer          DDRAM 0x00-0x0F, char 0 in [127:120]
//   line2_buffer          DDRAM 0x40-0x4F, same packing
//   ddram_addr            address counter
//   display_on            D bit of the last display-control instruction
//   busy                  busy counter non-zero
//   write_strobe          one-cycle pulse per accepted write
//   busy_violation        sticky: a write arrived while busy
module text_lcd_responder
    import lcd_pkg::*;
#(
    parameter int BUSY_SHORT_CYC = BUSY_SHORT_DEF,
    parameter int BUSY_LONG_CYC  = BUSY_LONG_DEF,
    parameter int CNT_W          = 17
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         lcd_rs,
    input  logic         lcd_rw,
    input  logic         lcd_en,
    input  logic [7:0]   lcd_data,
    output logic [127:0] line1_buffer,
    output logic [127:0] line2_buffer,
    output logic [6:0]   ddram_addr,
    output logic         display_on,
    output logic         busy,
    output logic         write_strobe,
    output logic         busy_violation
);

    localparam logic [CNT_W-1:0] CNT_ZERO  = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_SHORT = CNT_W'(BUSY_SHORT_CYC);
    localparam logic [CNT_W-1:0] CNT_LONG  = CNT_W'(BUSY_LONG_CYC);

    logic         xfer_valid_s, xfer_rs_s, xfer_rw_s;
    logic [7:0]   xfer_data_s;

    logic [127:0] line1_r, line2_r;
    logic [6:0]   ac_r;
    logic         id_r, display_on_r, busy_r, strobe_r, violation_r;
    logic [CNT_W-1:0] cnt_r;

    logic         accept_s, store_s, clear_s;
    logic [6:0]   ac_next_s;
    logic         id_next_s, disp_next_s;
    busy_load_e   load_s;
    logic [CNT_W-1:0] cnt_next_s;
    logic [6:0]   byte_lsb_s;
    logic         in_line1_s, in_line2_s;

    lcd_bus_sampler u_sampler (
        .clk        (clk),
        .rst_n      (rst_n),
        .lcd_rs     (lcd_rs),
        .lcd_rw     (lcd_rw),
        .lcd_en     (lcd_en),
        .lcd_data   (lcd_data),
        .xfer_valid (xfer_valid_s),
        .xfer_rs    (xfer_rs_s),
        .xfer_rw    (xfer_rw_s),
        .xfer_data  (xfer_data_s)
    );

    // Only 0x00-0x0F and 0x40-0x4F are backed by storage.
    assign in_line1_s = (ac_r[6:4] == 3'b000);
    assign in_line2_s = (ac_r[6:4] == 3'b100);
    assign byte_lsb_s = 7'd120 - {ac_r[3:0], 3'b000};

    // Write decode: data writes and instructions classified by highest set bit.
    always_comb begin
        accept_s    = xfer_valid_s & ~xfer_rw_s;
        ac_next_s   = ac_r;
        id_next_s   = id_r;
        disp_next_s = display_on_r;
        store_s     = 1'b0;
        clear_s     = 1'b0;
        load_s      = BUSY_NONE;
        if (accept_s) begin
            if (xfer_rs_s) begin
                store_s   = 1'b1;
                ac_next_s = ac_step(ac_r, id_r);
                load_s    = BUSY_SHORT;
            end else if ((xfer_data_s & OP_DDRAM) != 8'h00) begin
                ac_next_s = xfer_data_s[6:0];
                load_s    = BUSY_SHORT;
            end else if ((xfer_data_s & (OP_CGRAM | OP_FUNC | OP_SHIFT)) != 8'h00) begin
                load_s = BUSY_SHORT;
            end else if ((xfer_data_s & OP_DISPCTL) != 8'h00) begin
                disp_next_s = xfer_data_s[2];
                load_s      = BUSY_SHORT;
            end else if ((xfer_data_s & OP_ENTRY) != 8'h00) begin
                id_next_s = xfer_data_s[1];
                load_s    = BUSY_SHORT;
            end else if ((xfer_data_s & OP_HOME) != 8'h00) begin
                ac_next_s = LINE1_BASE;
                load_s    = BUSY_LONG;
            end else if ((xfer_data_s & OP_CLEAR) != 8'h00) begin
                clear_s   = 1'b1;
                ac_next_s = LINE1_BASE;
                id_next_s = 1'b1;
                load_s    = BUSY_LONG;
            end else begin
                load_s = BUSY_NONE;
            end
        end else begin
            load_s = BUSY_NONE;
        end
    end

    // Busy counter: reload on accepted writes, otherwise count down to zero.
    always_comb begin
        cnt_next_s = cnt_r;
        case (load_s)
            BUSY_LONG:  cnt_next_s = CNT_LONG;
            BUSY_SHORT: cnt_next_s = CNT_SHORT;
            default: begin
                if (cnt_r != CNT_ZERO) begin
                    cnt_next_s = cnt_r - CNT_ONE;
                end else begin
                    cnt_next_s = CNT_ZERO;
                end
            end
        endcase
    end

    // Control state: AC, entry direction, display bit, busy and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ac_r         <= LINE1_BASE;
            id_r         <= 1'b1;
            display_on_r <= 1'b0;
            cnt_r        <= CNT_ZERO;
            busy_r       <= 1'b0;
            strobe_r     <= 1'b0;
            violation_r  <= 1'b0;
        end else begin
            ac_r         <= ac_next_s;
            id_r         <= id_next_s;
            display_on_r <= disp_next_s;
            cnt_r        <= cnt_next_s;
            busy_r       <= (cnt_next_s != CNT_ZERO);
            strobe_r     <= accept_s;
            // The check sees the counter before this write reloads it.
            violation_r  <= violation_r | (accept_s & (cnt_r != CNT_ZERO));
        end
    end

    // DDRAM image: clear fills with spaces, data writes land at the current AC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            line1_r <= {16{LCD_SPACE}};
            line2_r <= {16{LCD_SPACE}};
        end else if (clear_s) begin
            line1_r <= {16{LCD_SPACE}};
            line2_r <= {16{LCD_SPACE}};
        end else if (store_s && in_line1_s) begin
            line1_r[byte_lsb_s +: 8] <= xfer_data_s;
        end else if (store_s && in_line2_s) begin
            line2_r[byte_lsb_s +: 8] <= xfer_data_s;
        end else begin
            line1_r <= line1_r;
            line2_r <= line2_r;
        end
    end

    assign line1_buffer   = line1_r;
    assign line2_buffer   = line2_r;
    assign ddram_addr     = ac_r;
    assign display_on     = display_on_r;
    assign busy           = busy_r;
    assign write_strobe   = strobe_r;
    assign busy_violation = violation_r;

endmodule

// File: tb/tb_text_lcd_responder.sv
// Bench for text_lcd_responder: directed steps and a randomized phase, each
// pin-level bus write compared against a behavioural DDRAM/AC/busy model.
module tb_text_lcd_responder;

    localparam int SHORT = 12;
    localparam int LONG  = 90;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         lcd_rs = 1'b0;
    logic         lcd_rw = 1'b0;
    logic         lcd_en = 1'b0;
    logic [7:0]   lcd_data = 8'h00;
    logic [127:0] line1_buffer, line2_buffer;
    logic [6:0]   ddram_addr;
    logic         display_on, busy, write_strobe, busy_violation;

    text_lcd_responder #(
        .BUSY_SHORT_CYC (SHORT),
        .BUSY_LONG_CYC  (LONG),
        .CNT_W          (17)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .lcd_rs         (lcd_rs),
        .lcd_rw         (lcd_rw),
        .lcd_en         (lcd_en),
        .lcd_data       (lcd_data),
        .line1_buffer   (line1_buffer),
        .line2_buffer   (line2_buffer),
        .ddram_addr     (ddram_addr),
        .display_on     (display_on),
        .busy           (busy),
        .write_strobe   (write_strobe),
        .busy_violation (busy_violation)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Behavioural model: full 128-byte address space, only windows are displayed.
    byte unsigned m_mem [128];
    logic [6:0]   m_ac;
    bit           m_id, m_disp, m_viol;
    int           m_bstart, m_blen;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic m_reset();
        for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
        m_ac = 7'h00; m_id = 1'b1; m_disp = 1'b0; m_viol = 1'b0;
        m_bstart = cyc; m_blen = 0;
    endtask

    function automatic logic [127:0] m_line(input int base);
        logic [127:0] v;
        for (int i = 0; i < 16; i++) v[120 - 8*i +: 8] = m_mem[base + i];
        return v;
    endfunction

    function automatic logic [6:0] m_move(input logic [6:0] a, input bit up);
        int v;
        if (up) v = (a == 7'h27) ? 'h40 : (a == 7'h67) ? 0 : (int'(a) + 1) % 128;
        else    v = (a == 7'h40) ? 'h27 : (a == 7'h00) ? 'h67 : int'(a) - 1;
        return 7'(v);
    endfunction

    // Apply one accepted write whose strobe is seen in cycle t (edge detected in t-1).
    task automatic m_apply(input bit rs, input logic [7:0] d, input int t);
        int top = -1;
        int load = -1;
        if (t - 1 < m_bstart + m_blen) m_viol = 1'b1;
        if (rs) begin
            if (m_ac < 16 || (m_ac >= 64 && m_ac < 80)) m_mem[m_ac] = d;
            m_ac = m_move(m_ac, m_id);
            load = SHORT;
        end else begin
            for (int b = 0; b < 8; b++) if (d[b]) top = b;
            case (top)
                7: m_ac = d[6:0];
                3: m_disp = d[2];
                2: m_id = d[1];
                1: m_ac = 7'h00;
                0: begin
                    for (int i = 0; i < 128; i++) m_mem[i] = 8'h20;
                    m_ac = 7'h00; m_id = 1'b1;
                end
                default: ;
            endcase
            if (top >= 2) load = SHORT;
            else if (top >= 0) load = LONG;
        end
        if (load >= 0) begin
            m_bstart = t;
            m_blen = load;
        end
    endtask

    task automatic check_state(input string tag);
        chk({tag, "_line1"}, line1_buffer, m_line(0));
        chk({tag, "_line2"}, line2_buffer, m_line(64));
        chk({tag, "_ac"}, ddram_addr, m_ac);
        chk({tag, "_disp"}, display_on, m_disp);
        chk({tag, "_busy"}, busy, (cyc >= m_bstart) && (cyc < m_bstart + m_blen));
        chk({tag, "_viol"}, busy_violation, m_viol);
    endtask

    // One pin-level bus cycle; returns on the negedge where the strobe is due.
    task automatic bus(input bit rs, input bit rw, input logic [7:0] d, input string tag);
        @(negedge clk);
        lcd_rs = rs; lcd_rw = rw; lcd_data = d; lcd_en = 1'b1;
        repeat (3) @(negedge clk);
        lcd_en = 1'b0;
        repeat (2) @(negedge clk);
        chk({tag, "_early"}, write_strobe, 1'b0);
        @(negedge clk);
        chk({tag, "_strobe"}, write_strobe, !rw);
        if (!rw) m_apply(rs, d, cyc);
        check_state(tag);
        lcd_rw = 1'b0;
    endtask

    // Idle until the model says the display is no longer busy.
    task automatic settle();
        while (cyc < m_bstart + m_blen) @(negedge clk);
    endtask

    initial begin
        string        ready;
        logic [127:0] exp_ready;
        int           r, seen;
        logic [7:0]   d;

        ready = "READY TO PLAY   ";
        exp_ready = "READY TO PLAY   ";

        // Reset values
        m_reset();
        repeat (3) @(negedge clk);
        chk("rst_line1", line1_buffer, {16{8'h20}});
        chk("rst_line2", line2_buffer, {16{8'h20}});
        chk("rst_ac", ddram_addr, 7'h00);
        chk("rst_disp", display_on, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_strobe", write_strobe, 1'b0);
        chk("rst_viol", busy_violation, 1'b0);
        rst_n = 1'b1;
        m_reset();

        // Title string on line 1
        bus(1'b0, 1'b0, 8'h01, "clear"); settle();
        bus(1'b0, 1'b0, 8'h80, "home1"); settle();
        for (int i = 0; i < 16; i++) begin
            bus(1'b1, 1'b0, ready[i], "ready"); settle();
        end
        chk("ready_line1", line1_buffer, exp_ready);
        chk("ready_ac", ddram_addr, 7'h10);
        chk("ready_viol", busy_violation, 1'b0);

        // Line 2 start
        bus(1'b0, 1'b0, 8'hC0, "line2"); settle();
        bus(1'b1, 1'b0, 8'h41, "dA"); settle();
        bus(1'b1, 1'b0, 8'h42, "dB"); settle();
        chk("ab_line2", line2_buffer[127:112], 16'h4142);
        chk("ab_ac", ddram_addr, 7'h42);

        // Wrap at 0x27 and back
        bus(1'b0, 1'b0, 8'hA7, "set27"); settle();
        bus(1'b1, 1'b0, 8'h58, "dX"); settle();
        chk("wrap_up_ac", ddram_addr, 7'h40);
        bus(1'b0, 1'b0, 8'h04, "decr"); settle();
        bus(1'b1, 1'b0, 8'h59, "dY"); settle();
        chk("wrap_dn_char", line2_buffer[127:120], 8'h59);
        chk("wrap_dn_ac", ddram_addr, 7'h27);

        // Read cycle ignored, display on
        bus(1'b1, 1'b1, 8'h41, "read"); settle();
        chk("read_ac", ddram_addr, 7'h27);
        bus(1'b0, 1'b0, 8'h0C, "dispon"); settle();
        chk("dispon", display_on, 1'b1);

        // Randomized writes against the model
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 99);
            if (r < 40) begin
                bus(1'b1, 1'b0, 8'($urandom_range(32, 126)), "rnd_data");
            end else if (r < 55) begin
                if ($urandom_range(0, 1) == 0) d = 8'h80 | 8'($urandom_range(0, 127));
                else d = 8'h80 | 8'($urandom_range(0, 15)) | ($urandom_range(0, 1) == 0 ? 8'h40 : 8'h00);
                bus(1'b0, 1'b0, d, "rnd_addr");
            end else if (r < 65) begin
                bus(1'b0, 1'b0, 8'h04 | 8'($urandom_range(0, 3)), "rnd_entry");
            end else if (r < 70) begin
                bus(1'b0, 1'b0, 8'h08 | 8'($urandom_range(0, 7)), "rnd_disp");
            end else if (r < 74) begin
                bus(1'b0, 1'b0, 8'h02 | 8'($urandom_range(0, 1)), "rnd_home");
            end else if (r < 77) begin
                bus(1'b0, 1'b0, 8'h01, "rnd_clear");
            end else if (r < 85) begin
                bus(1'b0, 1'b0, 8'($urandom_range(16, 127)), "rnd_misc");
            end else if (r < 90) begin
                bus(1'b0, 1'b0, 8'h00, "rnd_nop");
            end else begin
                bus(1'($urandom_range(0, 1)), 1'b1, 8'($urandom), "rnd_read");
            end
            settle();
        end

        // Busy lasts exactly the short time
        bus(1'b1, 1'b0, 8'h5A, "bz"); 
        repeat (SHORT - 1) @(negedge clk);
        chk("busy_last", busy, 1'b1);
        @(negedge clk);
        chk("busy_done", busy, 1'b0);
        settle();

        // Write detected right after the long busy expires: no violation
        bus(1'b0, 1'b0, 8'h01, "clr_a");
        repeat (LONG - 6) @(negedge clk);
        bus(1'b1, 1'b0, 8'h51, "ok_edge");
        chk("no_viol", busy_violation, 1'b0);

        // Async reset during a pending transfer while busy
        @(negedge clk);
        lcd_rs = 1'b1; lcd_data = 8'h57; lcd_en = 1'b1;
        repeat (2) @(negedge clk);
        lcd_en = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_line1", line1_buffer, {16{8'h20}});
        chk("arst_line2", line2_buffer, {16{8'h20}});
        chk("arst_ac", ddram_addr, 7'h00);
        chk("arst_busy", busy, 1'b0);
        chk("arst_viol", busy_violation, 1'b0);
        m_reset();
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (write_strobe) seen++;
        end
        chk("no_pending", seen, 0);
        check_state("post_rst");

        // Write detected on the last busy cycle: violation, sticky
        bus(1'b0, 1'b0, 8'h01, "clr_b");
        repeat (LONG - 7) @(negedge clk);
        bus(1'b1, 1'b0, 8'h56, "viol_edge");
        chk("viol_set", busy_violation, 1'b1);
        settle();
        bus(1'b1, 1'b0, 8'h57, "viol_sticky");
        settle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
